// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control bundle between the multi-cycle controller and the MIPS datapath
interface multicycle_control_if;
  logic [5:0] op_code;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       retire;
  logic       illegal;
  logic       bus_error;
  logic [3:0] state;
  modport master (
    input  op_code, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, retire, illegal, bus_error, state
  );
  modport slave (
    output op_code, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, retire, illegal, bus_error, state
  );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: fetch/decode/execute/memory/writeback sequencer for the multi-cycle MIPS datapath
module multicycle_control #(
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEXEC = 4'd6,
    RTWB   = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11
  } state_e;
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);
  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       waiting, expired;
  // Staying put only ever happens while stalled, so any non-stall cycle is a state change and clears the count.
  always_comb begin
    waiting = (state_q == FETCH || state_q == MEMRD || state_q == MEMWR) && !bus.mem_ready;
    expired = waiting && wait_q == LIMIT;
    wait_d  = (waiting && !expired) ? wait_q + 8'd1 : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end
  always_comb begin
    state_d           = state_q;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    bus.retire        = 1'b0;
    bus.illegal       = 1'b0;
    bus.bus_error     = expired;
    case (state_q)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.pc_write  = bus.mem_ready;
        bus.ir_write  = bus.mem_ready;
        state_d       = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.op_code)
          6'b000000:                                  state_d = RTEXEC;
          6'b100011, 6'b101011:                       state_d = MEMADR;
          6'b000100:                                  state_d = BRANCH;
          6'b001000, 6'b001100, 6'b001101, 6'b001010: state_d = IEXEC;
          6'b000010:                                  state_d = JUMP;
          default: begin
            state_d     = FETCH;
            bus.illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = (bus.op_code == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.i_or_d   = 1'b1;
        bus.mem_read = 1'b1;
        state_d      = bus.mem_ready ? MEMWB : (expired ? FETCH : MEMRD);
      end
      MEMWB: begin
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        bus.retire     = 1'b1;
        state_d        = FETCH;
      end
      MEMWR: begin
        bus.i_or_d    = 1'b1;
        bus.mem_write = 1'b1;
        bus.retire    = bus.mem_ready;
        state_d       = (bus.mem_ready || expired) ? FETCH : MEMWR;
      end
      RTEXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = RTWB;
      end
      RTWB: begin
        bus.reg_dst   = 1'b1;
        bus.reg_write = 1'b1;
        bus.retire    = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        bus.retire        = 1'b1;
        state_d           = FETCH;
      end
      IEXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = 2'b11;
        state_d       = IWB;
      end
      IWB: begin
        bus.reg_write = 1'b1;
        bus.retire    = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        bus.retire    = 1'b1;
        state_d       = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end
  assign bus.state = state_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction stream against a latency/event reference model with a scoreboard
module tb_multicycle_control;
  localparam int T = 16;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  multicycle_control_if bus();
  multicycle_control #(.TIMEOUT(T)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [18:0] ctl;
  assign ctl = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, bus.retire, bus.illegal, bus.bus_error};
  function automatic logic [18:0] c(int pcw, int pcwc, int iord, int mr, int mw, int irw,
                                    int m2r, int rd, int rw, int asa, int asb, int aop,
                                    int psrc, int ret, int ill, int be);
    return {pcw[0], pcwc[0], iord[0], mr[0], mw[0], irw[0], m2r[0], rd[0], rw[0], asa[0],
            asb[1:0], aop[1:0], psrc[1:0], ret[0], ill[0], be[0]};
  endfunction
  // Expected outputs for each state as listed in the control table
  logic [18:0] fetch_rdy, fetch_wait, fetch_be, dec, dec_ill, memadr, memrd, memrd_be, memwb;
  logic [18:0] memwr_wait, memwr_done, memwr_be, rtexec, rtwb, br, iexec, iwb, jmp;
  initial begin
    fetch_rdy  = c(1,0,0,1,0,1,0,0,0,0,1,0,0,0,0,0);
    fetch_wait = c(0,0,0,1,0,0,0,0,0,0,1,0,0,0,0,0);
    fetch_be   = c(0,0,0,1,0,0,0,0,0,0,1,0,0,0,0,1);
    dec        = c(0,0,0,0,0,0,0,0,0,0,3,0,0,0,0,0);
    dec_ill    = c(0,0,0,0,0,0,0,0,0,0,3,0,0,0,1,0);
    memadr     = c(0,0,0,0,0,0,0,0,0,1,2,0,0,0,0,0);
    memrd      = c(0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,0);
    memrd_be   = c(0,0,1,1,0,0,0,0,0,0,0,0,0,0,0,1);
    memwb      = c(0,0,0,0,0,0,1,0,1,0,0,0,0,1,0,0);
    memwr_wait = c(0,0,1,0,1,0,0,0,0,0,0,0,0,0,0,0);
    memwr_done = c(0,0,1,0,1,0,0,0,0,0,0,0,0,1,0,0);
    memwr_be   = c(0,0,1,0,1,0,0,0,0,0,0,0,0,0,0,1);
    rtexec     = c(0,0,0,0,0,0,0,0,0,1,0,2,0,0,0,0);
    rtwb       = c(0,0,0,0,0,0,0,1,1,0,0,0,0,1,0,0);
    br         = c(0,1,0,0,0,0,0,0,0,1,0,1,1,1,0,0);
    iexec      = c(0,0,0,0,0,0,0,0,0,1,2,3,0,0,0,0);
    iwb        = c(0,0,0,0,0,0,0,0,1,0,0,0,0,1,0,0);
    jmp        = c(1,0,0,0,0,0,0,0,0,0,0,0,2,1,0,0);
  end
  typedef struct {
    int          cyc;
    logic [3:0]  st;
    logic [18:0] ctl;
    logic [3:0]  pst;
    logic [18:0] pctl;
  } exp_t;
  exp_t sbq[$];
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  // 0 R-type, 1 lw, 2 sw, 3 beq, 4 I-type, 5 j, 6 unrecognised
  function automatic int cls(logic [5:0] op);
    case (op)
      6'b000000: return 0;
      6'b100011: return 1;
      6'b101011: return 2;
      6'b000100: return 3;
      6'b001000, 6'b001100, 6'b001101, 6'b001010: return 4;
      6'b000010: return 5;
      default: return 6;
    endcase
  endfunction
  // f = fetch stall cycles, m = memory stall cycles; a stall of T or more ends in a bus error
  task automatic run_instr(logic [5:0] op, int f, int m);
    exp_t e;
    int   len, k0, start;
    int   cl = cls(op);
    start = cyc;
    if (f >= T) begin
      len = T; e.st = 0; e.ctl = fetch_be; e.pst = 0; e.pctl = fetch_wait;
    end else begin
      case (cl)
        0: begin len = f + 4; e.st = 7;  e.ctl = rtwb;    e.pst = 6; e.pctl = rtexec;    end
        4: begin len = f + 4; e.st = 10; e.ctl = iwb;     e.pst = 9; e.pctl = iexec;     end
        3: begin len = f + 3; e.st = 8;  e.ctl = br;      e.pst = 1; e.pctl = dec;       end
        5: begin len = f + 3; e.st = 11; e.ctl = jmp;     e.pst = 1; e.pctl = dec;       end
        6: begin len = f + 2; e.st = 1;  e.ctl = dec_ill; e.pst = 0; e.pctl = fetch_rdy; end
        1: if (m < T) begin
             len = f + m + 5; e.st = 4; e.ctl = memwb; e.pst = 3; e.pctl = memrd;
           end else begin
             len = f + 3 + T; e.st = 3; e.ctl = memrd_be; e.pst = 3; e.pctl = memrd;
           end
        default: if (m < T) begin
             len = f + m + 4; e.st = 5; e.ctl = memwr_done;
             e.pst = (m == 0) ? 4'd2 : 4'd5; e.pctl = (m == 0) ? memadr : memwr_wait;
           end else begin
             len = f + 3 + T; e.st = 5; e.ctl = memwr_be; e.pst = 5; e.pctl = memwr_wait;
           end
      endcase
    end
    e.cyc = start + len - 1;
    sbq.push_back(e);
    for (int k = 0; k < len; k++) begin
      bus.op_code = op;
      bus.mem_ready = 1'($urandom_range(0, 1));
      k0 = k - (f + 3);
      if (k < f) bus.mem_ready = 1'b0;
      else if (k == f) bus.mem_ready = 1'b1;
      else if ((cl == 1 || cl == 2) && k0 >= 0) bus.mem_ready = (k0 < m) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
  endtask
  function automatic int pick_stall();
    int r = int'($urandom_range(0, 19));
    if (r < 8) return 0;
    if (r < 17) return int'($urandom_range(1, 5));
    if (r == 17) return T - 1;
    return T + int'($urandom_range(0, 2));
  endfunction
  logic [3:0]  prev_st;
  logic [18:0] prev_ctl;
  exp_t        got;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.retire || bus.illegal || bus.bus_error) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: ctrl %0h state %0d with nothing expected (cycle %0d)", ctl, bus.state, cyc);
        end else begin
          got = sbq.pop_front();
          chk("event_cycle", cyc, got.cyc);
          chk("event_state", 32'(bus.state), 32'(got.st));
          chk("event_ctrl", 32'(ctl), 32'(got.ctl));
          chk("prev_state", 32'(prev_st), 32'(got.pst));
          chk("prev_ctrl", 32'(prev_ctl), 32'(got.pctl));
        end
      end
    end
    prev_st = bus.state;
    prev_ctl = ctl;
  end
  logic [5:0] ops [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
                          6'b001100, 6'b001101, 6'b001010, 6'b000010};
  initial begin
    logic [5:0] op;
    reset = 1'b1;
    bus.op_code = 6'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_ctrl", 32'(ctl), 32'(fetch_wait));
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 3);
    run_instr(6'b001000, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b101011, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b000000, T, 0);
    run_instr(6'b100011, 0, T);
    run_instr(6'b101011, 1, T - 1);
    for (int i = 0; i < 250; i++) begin
      op = ($urandom_range(0, 11) < 9) ? ops[$urandom_range(0, 8)] : 6'($urandom_range(0, 63));
      run_instr(op, pick_stall(), pick_stall());
    end
    // sw interrupted by reset while stalled in the write
    bus.op_code = 6'b101011;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_reset_state", 32'(bus.state), 32'd5);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post_reset_state", 32'(bus.state), 32'd0);
    chk("post_reset_mem_write", 32'(bus.mem_write), 32'd0);
    run_instr(6'b000000, T, 0);
    run_instr(6'b101011, 0, 2);
    bus.mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
